// File: rtl/odd_seq_pkg.sv
// Shared types and constants for the odd-counter test sequencer.
package odd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] STEP_UP   = 3'd2;
    localparam logic [2:0] STEP_DN   = 3'd6;
    localparam logic [7:0] MISR_POLY = 8'h1D;

endpackage

// File: rtl/odd_counter_sequencer_if.sv
// Control/status bundle between a run controller (master) and the sequencer (slave).
interface odd_counter_sequencer_if #(
    parameter int LEN_W = 8,
    parameter int SIG_W = 8
) ();
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] up_len;
    logic [LEN_W-1:0] dn_len;
    logic             busy;
    logic             done;
    logic             err;
    logic [SIG_W-1:0] sig;

    modport master (
        output start, abort, up_len, dn_len,
        input  busy, done, err, sig
    );

    modport slave (
        input  start, abort, up_len, dn_len,
        output busy, done, err, sig
    );
endinterface

// File: rtl/odd_seq_misr.sv
// Multiple-input signature register folding 3-bit counter samples into SIG_W bits.
module odd_seq_misr
    import odd_seq_pkg::*;
#(
    parameter int SIG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             en,
    input  logic [2:0]       d,
    output logic [SIG_W-1:0] sig
);
    localparam logic [SIG_W-1:0] POLY = SIG_W'(MISR_POLY);

    logic fb;
    assign fb = ^(sig & POLY);

    always_ff @(posedge clk) begin
        if (rst)       sig <= '0;
        else if (init) sig <= '1;
        else if (en)   sig <= {sig[SIG_W-2:0], fb} ^ {{(SIG_W-3){1'b0}}, d};
    end
endmodule

// File: rtl/odd_counter_sequencer.sv
// Drives the odd up/down counter through an up then a down phase and checks every step.
// Optional MISR signature on sig when SEQ_MISR_EN is defined; otherwise sig is tied to 0.
module odd_counter_sequencer
    import odd_seq_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int SIG_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    odd_counter_sequencer_if.slave  ctl,
    input  logic [2:0]              p_in,
    output logic                    x
);
    state_t           state, state_nx;
    logic [LEN_W-1:0] cnt, cnt_nx;
    logic [LEN_W-1:0] dn_lat, dn_lat_nx;
    logic [2:0]       prev_p;
    logic [2:0]       exp_p;
    logic             prev_x;
    logic             chk_vld;
    logic             accept, active, last, step_bad;

    assign accept = (state == IDLE) && ctl.start;
    assign active = (state == UP) || (state == DOWN);
    assign last   = (cnt == LEN_W'(1));

    // Counter sampled this cycle must be one step on from the previous sample.
    assign exp_p    = prev_p + (prev_x ? STEP_DN : STEP_UP);
    assign step_bad = active && (!p_in[0] || (chk_vld && (p_in != exp_p)));

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_nx  = state;
        cnt_nx    = cnt;
        dn_lat_nx = dn_lat;
        unique case (state)
            IDLE: begin
                if (ctl.start) begin
                    dn_lat_nx = ctl.dn_len;
                    if (ctl.up_len != '0) begin
                        state_nx = UP;
                        cnt_nx   = ctl.up_len;
                    end else if (ctl.dn_len != '0) begin
                        state_nx = DOWN;
                        cnt_nx   = ctl.dn_len;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            UP: begin
                if (ctl.abort) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (last) begin
                    state_nx = (dn_lat != '0) ? DOWN : DONE;
                    cnt_nx   = dn_lat;
                end else begin
                    cnt_nx = cnt - LEN_W'(1);
                end
            end
            DOWN: begin
                if (ctl.abort || last) begin
                    state_nx = ctl.abort ? IDLE : DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - LEN_W'(1);
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decode the next state so they change on the edge that enters it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dn_lat   <= '0;
            x        <= 1'b0;
            ctl.busy <= 1'b0;
            ctl.done <= 1'b0;
            ctl.err  <= 1'b0;
            prev_p   <= '0;
            prev_x   <= 1'b0;
            chk_vld  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            dn_lat   <= dn_lat_nx;
            x        <= (state_nx == DOWN);
            ctl.busy <= (state_nx == UP) || (state_nx == DOWN);
            ctl.done <= (state_nx == DONE);
            if (accept) begin
                ctl.err <= 1'b0;
                chk_vld <= 1'b0;
            end else if (active) begin
                prev_p  <= p_in;
                prev_x  <= x;
                chk_vld <= 1'b1;
                if (step_bad) ctl.err <= 1'b1;
            end
        end
    end

`ifdef SEQ_MISR_EN
    logic [SIG_W-1:0] sig_q;

    odd_seq_misr #(.SIG_W(SIG_W)) u_misr (
        .clk  (clk),
        .rst  (rst),
        .init (accept),
        .en   (active),
        .d    (p_in),
        .sig  (sig_q)
    );

    assign ctl.sig = sig_q;
`else
    assign ctl.sig = '0;
`endif

endmodule

// File: tb/tb_odd_counter_sequencer.sv
// Self-checking bench: a free-running odd counter model plus a per-cycle run model of the sequencer.
module tb_odd_counter_sequencer;
    localparam int LEN_W = 8;
    localparam int SIG_W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] p_in;
    logic       x;
    logic [2:0] cnt;
    logic       cnt_ld;
    logic [2:0] cnt_ld_val;
    logic       ovr;
    logic [2:0] ovr_val;
    logic [SIG_W-1:0] last_sig;
    logic [SIG_W-1:0] sig_a;
    logic [SIG_W-1:0] sig_b;

    int n_cmp = 0;
    int n_bad = 0;

    odd_counter_sequencer_if #(.LEN_W(LEN_W), .SIG_W(SIG_W)) ctl ();

    odd_counter_sequencer #(.LEN_W(LEN_W), .SIG_W(SIG_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctl  (ctl.slave),
        .p_in (p_in),
        .x    (x)
    );

    always #5 clk = ~clk;

    // The counter under test: steps +2 (x=0) or -2 (x=1) on every rising edge.
    always @(posedge clk) begin
        if (cnt_ld) cnt <= cnt_ld_val;
        else        cnt <= x ? cnt - 3'd2 : cnt + 3'd2;
    end

    assign p_in = ovr ? ovr_val : cnt;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int misr_next(input int s, input int d);
        int fb;
        fb = $countones(s & 'h1D) % 2;
        return (((s * 2) + fb) % 256) ^ d;
    endfunction

    // Called at posedge+1; leaves the bench at posedge+1 of an idle cycle.
    task automatic run(input string name, input int up, input int dn, input int p0,
                       input int fk, input int fv, input int abort_k,
                       input int start_k, input int rst_k);
        int  stop_k, last_k, cm, pres, prev, errm, sigm, sig_exp;
        bit  dead, in_up, in_dn, in_done, xe, be, has_prev, prevx, viol;
        stop_k = (abort_k >= 0) ? abort_k : rst_k;
        last_k = (stop_k >= 0) ? stop_k + 2 : up + dn + 1;

        ctl.start  = 1'b1;
        ctl.up_len = LEN_W'(up);
        ctl.dn_len = LEN_W'(dn);
        cnt_ld     = 1'b1;
        cnt_ld_val = 3'(p0);
        @(posedge clk); #1;
        ctl.start = 1'b0;
        cnt_ld    = 1'b0;

        cm = p0; prev = 0; prevx = 0; has_prev = 0; errm = 0; sigm = 255;
        for (int k = 0; k <= last_k; k++) begin
            dead    = (stop_k >= 0) && (k > stop_k);
            in_up   = !dead && (k < up);
            in_dn   = !dead && (k >= up) && (k < up + dn);
            in_done = !dead && (k == up + dn);
            xe = in_dn;
            be = in_up || in_dn;
            pres = (k == fk) ? fv : cm;

            ovr       = (k == fk);
            ovr_val   = 3'(fv);
            ctl.abort = (k == abort_k);
            rst       = (k == rst_k);
            ctl.start = (k == start_k);
            if (k == start_k) begin
                ctl.up_len = LEN_W'(3);
                ctl.dn_len = LEN_W'(1);
            end

`ifdef SEQ_MISR_EN
            sig_exp = sigm;
`else
            sig_exp = 0;
`endif
            @(negedge clk);
            check($sformatf("%s x k%0d", name, k),    32'(x),        32'(xe));
            check($sformatf("%s busy k%0d", name, k), 32'(ctl.busy), 32'(be));
            check($sformatf("%s done k%0d", name, k), 32'(ctl.done), 32'(in_done));
            check($sformatf("%s err k%0d", name, k),  32'(ctl.err),  32'(errm));
            check($sformatf("%s sig k%0d", name, k),  32'(ctl.sig),  32'(sig_exp));
            last_sig = ctl.sig;

            if (be) begin
                viol = (pres % 2 == 0) || (has_prev && (pres != (prev + (prevx ? 6 : 2)) % 8));
                if (viol) errm = 1;
                sigm = misr_next(sigm, pres);
                prev = pres; prevx = xe; has_prev = 1;
            end
            if (k == rst_k) begin
                errm = 0;
                sigm = 0;
            end
            cm = (cm + (xe ? 6 : 2)) % 8;
            @(posedge clk); #1;
        end
        ovr = 1'b0; ctl.abort = 1'b0; ctl.start = 1'b0; rst = 1'b0;
    endtask

    initial begin
        int up, dn, p0, fk;
        rst = 1'b1; ctl.start = 1'b0; ctl.abort = 1'b0;
        ctl.up_len = '0; ctl.dn_len = '0;
        cnt_ld = 1'b1; cnt_ld_val = 3'd1; ovr = 1'b0; ovr_val = 3'd0;
        last_sig = '0; sig_a = '0; sig_b = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset x",    32'(x),        32'd0);
        check("reset busy", 32'(ctl.busy), 32'd0);
        check("reset done", 32'(ctl.done), 32'd0);
        check("reset err",  32'(ctl.err),  32'd0);
        check("reset sig",  32'(ctl.sig),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0; cnt_ld = 1'b0;
        @(posedge clk); #1;

        run("basic", 16, 16, 2 * $urandom_range(0, 3) + 1, -1, 0, -1, -1, -1);
        run("up0",    0,  4, 2 * $urandom_range(0, 3) + 1, -1, 0, -1, -1, -1);
        run("zero",   0,  0, 2 * $urandom_range(0, 3) + 1, -1, 0, -1, -1, -1);
        run("f35",    4,  8, 1, 8, 5, -1, -1, -1);
        run("clr",    3,  3, 2 * $urandom_range(0, 3) + 1, -1, 0, -1, -1, -1);
        run("even0",  5,  3, 2 * $urandom_range(0, 3) + 1, 0, 4, -1, -1, -1);
        run("abort", 10, 10, 2 * $urandom_range(0, 3) + 1, -1, 0, 2, -1, -1);
        run("sbusy",  6,  6, 2 * $urandom_range(0, 3) + 1, -1, 0, -1, 3, -1);
        run("rstdn",  4,  8, 2 * $urandom_range(0, 3) + 1, -1, 0, -1, -1, 8);

        for (int i = 0; i < 6; i++) begin
            up = $urandom_range(0, 12);
            dn = $urandom_range(0, 12);
            p0 = 2 * $urandom_range(0, 3) + 1;
            fk = ($urandom_range(0, 1) == 1 && (up + dn) > 0) ? $urandom_range(0, up + dn - 1) : -1;
            run($sformatf("rnd%0d", i), up, dn, p0, fk, $urandom_range(0, 7), -1, -1, -1);
        end

        run("misr_a", 8, 8, 1, -1, 0, -1, -1, -1);
        sig_a = last_sig;
        run("misr_b", 8, 8, 1, 5, 7, -1, -1, -1);
        sig_b = last_sig;
`ifdef SEQ_MISR_EN
        check("misr flip changes sig", 32'(sig_a != sig_b), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
